// File: rtl/erode_seq.sv
// Sequential 3x3 binary erosion over a flattened image: latch image+mask on start,
// compute one output row per clock, pulse done after the last row.

module erode_seq_pixel (
  input  logic [8:0] nbhd,
  input  logic [8:0] mask,
  output logic       pix
);
  // Unmasked neighbours are don't-care, so an all-zero mask yields 1.
  assign pix = &(nbhd | ~mask);
endmodule

module erode_seq #(
  parameter int Width  = 8,
  parameter int Height = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [Width*Height-1:0] imageIn,
  input  logic [8:0]              mask,
  output logic                    busy,
  output logic                    done,
  output logic [Width*Height-1:0] imageOut
);
  localparam int CntW = $clog2(Height);
  localparam logic [CntW-1:0] LastRow = CntW'(Height - 1);

  typedef enum logic {IDLE, RUN} state_t;
  state_t state, nextState;

  // Packed index Height-1-r holds image row r, matching the flat bit layout.
  logic [Height-1:0][Width-1:0] imgReg, outReg;
  logic [8:0]                   maskReg;
  logic [CntW-1:0]              row, midIdx;
  logic                         lastRow;
  logic [Width-1:0]             upRow, midRow, lowRow, rowOut;
  logic [Width+1:0]             upPad, midPad, lowPad;
  logic [Width-1:0][8:0]        nbhd;

  assign imageOut = outReg;
  assign midIdx   = LastRow - row;
  assign lastRow  = (row == LastRow);

  always_comb begin
    upRow  = '0;
    lowRow = '0;
    midRow = imgReg[midIdx];
    if (row != '0) upRow  = imgReg[midIdx + 1'b1];
    if (!lastRow)  lowRow = imgReg[midIdx - 1'b1];
  end

  // Zero columns on both sides model out-of-image pixels.
  assign upPad  = {1'b0, upRow,  1'b0};
  assign midPad = {1'b0, midRow, 1'b0};
  assign lowPad = {1'b0, lowRow, 1'b0};

  for (genvar k = 0; k < Width; k++) begin : gPix
    assign nbhd[k] = {upPad[k+2 -: 3], midPad[k+2 -: 3], lowPad[k+2 -: 3]};
    erode_seq_pixel uPix (
      .nbhd(nbhd[k]),
      .mask(maskReg),
      .pix (rowOut[k])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE: if (start)   nextState = RUN;
      RUN:  if (lastRow) nextState = IDLE;
      default:           nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      imgReg  <= '0;
      outReg  <= '0;
      maskReg <= '0;
      row     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            imgReg  <= imageIn;
            maskReg <= mask;
            outReg  <= '0;
            row     <= '0;
            busy    <= 1'b1;
          end
        end
        RUN: begin
          outReg[midIdx] <= rowOut;
          busy           <= !lastRow;
          done           <= lastRow;
          if (!lastRow) row <= row + 1'b1;
        end
        default: done <= 1'b0;
      endcase
    end
  end
endmodule
